// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and bus bit constants
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic BIT_ACK  = 1'b0;
    localparam logic BIT_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_edge_detect.sv
// rtl/i2c_edge_detect.sv - START/STOP and SCL edge detection on synchronized bus lines
module i2c_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic start_o,
    output logic stop_o,
    output logic scl_rise_o,
    output logic scl_fall_o
);

    logic scl_q;
    logic sda_q;

    // Previous samples; reset to idle-bus levels so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_i;
            sda_q <= sda_i;
        end
    end

    assign start_o    = scl_i & sda_q & ~sda_i;
    assign stop_o     = scl_i & ~sda_q & sda_i;
    assign scl_rise_o = ~scl_q & scl_i;
    assign scl_fall_o = scl_q & ~scl_i;

endmodule

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target exposing a byte-wide register file
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h48,
    parameter int         REG_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scl_i,
    input  logic                sda_i,
    output logic                scl_o,
    output logic                sda_o,
    input  logic                wr_en,
    input  logic [REG_BITS-1:0] wr_addr,
    input  logic [7:0]          wr_data,
    input  logic [REG_BITS-1:0] rd_addr,
    output logic [7:0]          rd_data,
    output logic                bus_wr,
    output logic [REG_BITS-1:0] bus_wr_addr,
    output logic [7:0]          bus_wr_data,
    output logic                busy
);

    localparam int NUM_REGS = 1 << REG_BITS;

    i2c_state_e          state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic [REG_BITS-1:0] ptr_q, ptr_d;
    logic                sda_o_q, sda_o_d;
    logic                busy_q, busy_d;
    logic                bus_we;
    logic                bus_wr_q;
    logic [REG_BITS-1:0] bus_wr_addr_q;
    logic [7:0]          bus_wr_data_q;
    logic [7:0]          rd_data_q;
    logic [7:0]          regs_q [NUM_REGS];

    logic                start, stop, scl_rise, scl_fall;
    logic [7:0]          byte_in;
    logic [7:0]          rd_byte;

    i2c_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .start_o    (start),
        .stop_o     (stop),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall)
    );

    assign byte_in = {shift_q[6:0], sda_i};
    assign rd_byte = regs_q[ptr_q];

    // Bus protocol: bit shifting, ACK phases and pointer handling; SDA only moves after a detected SCL fall.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        sda_o_d = sda_o_q;
        busy_d  = busy_q;
        bus_we  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
            sda_o_d = 1'b1;
            busy_d  = 1'b0;
        end else if (start) begin
            state_d = ST_ADDR;
            cnt_d   = 3'd0;
            sda_o_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (byte_in[7:1] == DEV_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                // First fall drives the ACK; with SDA already low the next fall ends the 9th clock.
                ST_ADDR_ACK: if (scl_fall) begin
                    if (sda_o_q) begin
                        sda_o_d = BIT_ACK;
                    end else begin
                        cnt_d = 3'd0;
                        case (shift_q[0])
                            RW_READ: begin
                                shift_d = rd_byte;
                                sda_o_d = rd_byte[7];
                                state_d = ST_RDATA;
                            end
                            RW_WRITE: begin
                                sda_o_d = 1'b1;
                                state_d = ST_PTR;
                            end
                        endcase
                    end
                end
                ST_PTR: if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        ptr_d   = byte_in[REG_BITS-1:0];
                        state_d = ST_PTR_ACK;
                    end
                end
                ST_WDATA: if (scl_rise) begin
                    shift_d = byte_in;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        bus_we  = 1'b1;
                        ptr_d   = ptr_q + 1'b1;
                        state_d = ST_WDATA_ACK;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                    if (sda_o_q) begin
                        sda_o_d = BIT_ACK;
                    end else begin
                        sda_o_d = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = ST_WDATA;
                    end
                end
                ST_RDATA: if (scl_fall) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        sda_o_d = 1'b1;
                        state_d = ST_RDATA_ACK;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        sda_o_d = shift_q[6];
                    end
                end
                // Rise samples the initiator's ACK; the following fall can only occur after an ACK.
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_i == BIT_NACK) begin
                            state_d = ST_IGNORE;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end else if (scl_fall) begin
                        shift_d = rd_byte;
                        sda_o_d = rd_byte[7];
                        cnt_d   = 3'd0;
                        state_d = ST_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    // Protocol state and bus-side output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 3'd0;
            shift_q       <= 8'h00;
            ptr_q         <= '0;
            sda_o_q       <= 1'b1;
            busy_q        <= 1'b0;
            bus_wr_q      <= 1'b0;
            bus_wr_addr_q <= '0;
            bus_wr_data_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            sda_o_q  <= sda_o_d;
            busy_q   <= busy_d;
            bus_wr_q <= bus_we;
            if (bus_we) begin
                bus_wr_addr_q <= ptr_q;
                bus_wr_data_q <= byte_in;
            end
        end
    end

    // Register file: the bus write is ordered last so it wins a same-register collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            if (wr_en) begin
                regs_q[wr_addr] <= wr_data;
            end
            if (bus_we) begin
                regs_q[ptr_q] <= byte_in;
            end
        end
    end

    // Registered local read port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= regs_q[rd_addr];
        end
    end

    assign scl_o       = 1'b1;
    assign sda_o       = sda_o_q;
    assign busy        = busy_q;
    assign bus_wr      = bus_wr_q;
    assign bus_wr_addr = bus_wr_addr_q;
    assign bus_wr_data = bus_wr_data_q;
    assign rd_data     = rd_data_q;

endmodule
